// File: rtl/l2_cache_pkg.sv
// l2_cache_assoc shared types: controller states and way-index sizing.
// Keeps the top and the LRU unit agreeing on way-index width.
package l2_cache_pkg;

  typedef enum logic [1:0] {
    LOOKUP,
    WRITEBACK,
    FILL
  } state_t;

  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/l2_lru_set.sv
// True-LRU age update for one set: hit way goes to age 0, younger ways age.
// The victim is the way holding the maximum age WAYS-1.
module l2_lru_set
  import l2_cache_pkg::*;
#(
  parameter int WAYS = 2,
  localparam int WW = way_bits(WAYS)
) (
  input  logic               access_valid,
  input  logic [WW-1:0]      access_way,
  input  logic [WAYS*WW-1:0] ages_in,
  output logic [WW-1:0]      victim_way,
  output logic [WAYS*WW-1:0] ages
);

  if (WAYS == 1) begin : g_dm
    assign victim_way = '0;
    assign ages       = '0;
  end else begin : g_lru
    logic [WW-1:0] w_old;

    assign w_old = ages_in[access_way*WW +: WW];

    always_comb begin
      ages = ages_in;
      if (access_valid) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WW'(w) == access_way)
            ages[w*WW +: WW] = '0;
          else if (ages_in[w*WW +: WW] < w_old)
            ages[w*WW +: WW] = ages_in[w*WW +: WW] + 1'b1;
        end
      end
    end

    always_comb begin
      victim_way = '0;
      for (int w = 0; w < WAYS; w++)
        if (ages_in[w*WW +: WW] == WW'(WAYS - 1))
          victim_way = WW'(w);
    end
  end

endmodule

// File: rtl/l2_cache_assoc.sv
// N-way set-associative write-back/write-allocate L2 with true LRU.
// Hits complete combinationally; misses run WRITEBACK/FILL, then re-lookup.
module l2_cache_assoc
  import l2_cache_pkg::*;
#(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 128,
  parameter int SET_BITS = 4,
  parameter int WAYS     = 2,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l2_read,
  input  logic              l2_write,
  input  logic [ADDR_W-1:0] l2_addr,
  input  logic [DATA_W-1:0] l2_wdata,
  output logic [DATA_W-1:0] l2_rdata,
  output logic              l2_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  cnt_access,
  output logic [CNT_W-1:0]  cnt_hit,
  output logic [CNT_W-1:0]  cnt_wb
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = ADDR_W - SET_BITS;
  localparam int WW    = way_bits(WAYS);
  localparam int AV    = WAYS * WW;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_data  [SETS][WAYS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [WAYS-1:0]   r_valid [SETS];
  logic [WAYS-1:0]   r_dirty [SETS];

  logic [SET_BITS-1:0] r_vic_idx;
  logic [WW-1:0]       r_vic_way;
  logic                r_first;

  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [CNT_W-1:0]  r_cnt_access;
  logic [CNT_W-1:0]  r_cnt_hit;
  logic [CNT_W-1:0]  r_cnt_wb;

  logic                w_req;
  logic [SET_BITS-1:0] w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic [WW-1:0]       w_hit_way;
  logic                w_inv_found;
  logic [WW-1:0]       w_inv_way;
  logic [WW-1:0]       w_lru_way;
  logic [WW-1:0]       w_vic_way;
  logic                w_vic_dirty;
  logic                w_lookup;
  logic                w_hit_ok;
  logic                w_miss;
  logic [AV-1:0]       w_age_cur;
  logic [AV-1:0]       w_age_nxt;

  assign w_req = l2_read ^ l2_write;
  assign w_idx = l2_addr[SET_BITS-1:0];
  assign w_tag = l2_addr[ADDR_W-1:SET_BITS];

  // Descending scan leaves the lowest-index invalid way selected.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WW'(w);
      end
    end
  end

  assign w_vic_way   = w_inv_found ? w_inv_way : w_lru_way;
  assign w_vic_dirty = r_valid[w_idx][w_vic_way]
                     & r_dirty[w_idx][w_vic_way];

  assign w_lookup = (r_state == LOOKUP) && w_req;
  assign w_hit_ok = w_lookup && w_hit;
  assign w_miss   = w_lookup && !w_hit;

  assign l2_ready = !w_req || w_hit_ok;
  assign l2_rdata = (w_hit_ok && l2_read)
                  ? r_data[w_idx][w_hit_way] : '0;

  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cnt_access = r_cnt_access;
  assign cnt_hit    = r_cnt_hit;
  assign cnt_wb     = r_cnt_wb;

  if (WAYS > 1) begin : g_age
    logic [AV-1:0] r_age [SETS];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            r_age[s][w*WW +: WW] <= WW'(w);
      end else if (w_hit_ok) begin
        r_age[w_idx] <= w_age_nxt;
      end
    end

    assign w_age_cur = r_age[w_idx];
  end else begin : g_noage
    assign w_age_cur = '0;
  end

  l2_lru_set #(
    .WAYS(WAYS)
  ) u_lru (
    .access_valid(w_hit_ok),
    .access_way  (w_hit_way),
    .ages_in     (w_age_cur),
    .victim_way  (w_lru_way),
    .ages        (w_age_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LOOKUP;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      LOOKUP:
        if (w_miss)
          w_state_nxt = w_vic_dirty ? WRITEBACK : FILL;
      WRITEBACK:
        if (mem_ready) w_state_nxt = FILL;
      FILL:
        if (mem_ready) w_state_nxt = LOOKUP;
      default:
        w_state_nxt = LOOKUP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_data[s][w] <= '0;
          r_tag[s][w]  <= '0;
        end
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
    end else if (w_hit_ok && l2_write) begin
      r_data[w_idx][w_hit_way]  <= l2_wdata;
      r_dirty[w_idx][w_hit_way] <= 1'b1;
    end else if (r_state == FILL && mem_ready) begin
      r_data[r_vic_idx][r_vic_way]  <= mem_rdata;
      r_tag[r_vic_idx][r_vic_way]   <= w_tag;
      r_valid[r_vic_idx][r_vic_way] <= 1'b1;
      r_dirty[r_vic_idx][r_vic_way] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_vic_idx    <= '0;
      r_vic_way    <= '0;
      r_first      <= 1'b1;
      r_cnt_access <= '0;
      r_cnt_hit    <= '0;
      r_cnt_wb     <= '0;
    end else begin
      unique case (r_state)
        LOOKUP: begin
          if (w_hit_ok) begin
            r_first      <= 1'b1;
            r_cnt_access <= r_cnt_access + 1'b1;
            if (r_first) r_cnt_hit <= r_cnt_hit + 1'b1;
          end else if (w_miss) begin
            r_first   <= 1'b0;
            r_vic_idx <= w_idx;
            r_vic_way <= w_vic_way;
            if (w_vic_dirty) begin
              r_mem_write <= 1'b1;
              r_mem_addr  <= {r_tag[w_idx][w_vic_way], w_idx};
              r_mem_wdata <= r_data[w_idx][w_vic_way];
              r_cnt_wb    <= r_cnt_wb + 1'b1;
            end else begin
              r_mem_read <= 1'b1;
              r_mem_addr <= l2_addr;
            end
          end
        end
        WRITEBACK:
          if (mem_ready) begin
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_addr  <= l2_addr;
          end
        FILL:
          if (mem_ready) r_mem_read <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache_assoc.sv
// Directed bench for l2_cache_assoc (SET_BITS=4, WAYS=2) with a
// one-cycle-latency memory responder and hand-computed expectations.
module tb_l2_cache_assoc;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         l2_read = 1'b0;
  logic         l2_write = 1'b0;
  logic [27:0]  l2_addr = '0;
  logic [127:0] l2_wdata = '0;
  logic [127:0] l2_rdata;
  logic         l2_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
  logic [31:0]  cnt_access;
  logic [31:0]  cnt_hit;
  logic [31:0]  cnt_wb;

  int n_chk = 0;
  int n_pass = 0;

  logic         mem_hold = 1'b0;
  logic [127:0] mem_model [logic [27:0]];
  int           rd_seen = 0;
  int           wb_seen = 0;
  int           n_overlap = 0;
  logic [27:0]  last_rd_addr = '0;
  logic [27:0]  last_wb_addr = '0;
  logic [127:0] last_wb_data = '0;

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] D1 = {4{32'h1111_0001}};
  localparam logic [127:0] D2 = {4{32'h2222_0002}};
  localparam logic [127:0] D3 = {4{32'h3333_0003}};

  l2_cache_assoc #(
    .ADDR_W(28), .DATA_W(128), .SET_BITS(4), .WAYS(2), .CNT_W(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .l2_read   (l2_read),
    .l2_write  (l2_write),
    .l2_addr   (l2_addr),
    .l2_wdata  (l2_wdata),
    .l2_rdata  (l2_rdata),
    .l2_ready  (l2_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .cnt_access(cnt_access),
    .cnt_hit   (cnt_hit),
    .cnt_wb    (cnt_wb)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rd_model(input logic [27:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {4{4'h0, a}};
  endfunction

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) n_overlap++;
      if (!mem_hold && (mem_read || mem_write) && !mem_ready) begin
        mem_ready = 1'b1;
        if (mem_write) begin
          mem_model[mem_addr] = mem_wdata;
          wb_seen++;
          last_wb_addr = mem_addr;
          last_wb_data = mem_wdata;
        end else begin
          mem_rdata = rd_model(mem_addr);
          rd_seen++;
          last_rd_addr = mem_addr;
        end
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  task automatic req(input logic rd, input logic wr,
                     input logic [27:0] a, input logic [127:0] wd,
                     output logic [127:0] q, output int cyc);
    l2_read  = rd;
    l2_write = wr;
    l2_addr  = a;
    l2_wdata = wd;
    q   = '0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      cyc++;
      if (l2_ready) begin
        q = l2_rdata;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    l2_read  = 1'b0;
    l2_write = 1'b0;
  endtask

  initial begin
    logic [127:0] q;
    int           cyc;
    mem_model[28'h10] = PAT_A5;

    repeat (3) @(negedge clk);
    check("rst_ready", l2_ready, 1);
    check("rst_mem_rd", mem_read, 0);
    check("rst_mem_wr", mem_write, 0);
    check("rst_cnt_acc", cnt_access, 0);
    reset = 1'b0;
    @(negedge clk);

    req(1, 0, 28'h10, '0, q, cyc);
    check("t1_cyc", cyc, 3);
    check("t1_rdata", q, PAT_A5);
    check("t1_rd_addr", last_rd_addr, 28'h10);
    check("t1_rd_seen", rd_seen, 1);
    check("t1_acc", cnt_access, 1);
    check("t1_hit", cnt_hit, 0);

    req(1, 0, 28'h20, '0, q, cyc);
    check("t2_cyc", cyc, 3);
    check("t2_rdata", q, {4{32'h0000_0020}});
    req(1, 0, 28'h10, '0, q, cyc);
    check("t3_cyc", cyc, 1);
    check("t3_rdata", q, PAT_A5);
    req(1, 0, 28'h20, '0, q, cyc);
    check("t4_cyc", cyc, 1);
    check("t4_hit", cnt_hit, 2);
    check("t4_rd_seen", rd_seen, 2);

    req(0, 1, 28'h10, D1, q, cyc);
    check("t5_cyc", cyc, 1);
    req(1, 0, 28'h20, '0, q, cyc);
    check("t6_cyc", cyc, 1);
    req(1, 0, 28'h30, '0, q, cyc);
    check("t7_cyc", cyc, 5);
    check("t7_wb_addr", last_wb_addr, 28'h10);
    check("t7_wb_data", last_wb_data, D1);
    check("t7_rd_addr", last_rd_addr, 28'h30);
    check("t7_rdata", q, {4{32'h0000_0030}});
    check("t7_cnt_wb", cnt_wb, 1);
    check("t7_acc", cnt_access, 7);
    check("t7_hit", cnt_hit, 4);

    req(0, 1, 28'h45, D2, q, cyc);
    check("t8_cyc", cyc, 3);
    check("t8_rd_addr", last_rd_addr, 28'h45);
    req(1, 0, 28'h45, '0, q, cyc);
    check("t9_rdata", q, D2);
    req(1, 0, 28'h55, '0, q, cyc);
    check("t10_cyc", cyc, 3);
    req(1, 0, 28'h65, '0, q, cyc);
    check("t11_cyc", cyc, 5);
    check("t11_wb_addr", last_wb_addr, 28'h45);
    check("t11_wb_data", last_wb_data, D2);
    check("t11_cnt_wb", cnt_wb, 2);

    req(0, 1, 28'h20, D3, q, cyc);
    req(0, 1, 28'h30, D1, q, cyc);
    check("t12_acc", cnt_access, 13);
    check("t12_hit", cnt_hit, 7);

    mem_hold = 1'b1;
    l2_read  = 1'b1;
    l2_addr  = 28'h40;
    @(negedge clk);
    check("wb_mem_wr", mem_write, 1);
    check("wb_mem_addr", mem_addr, 28'h20);
    check("wb_mem_wdata", mem_wdata, D3);
    check("wb_cnt_wb", cnt_wb, 3);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_wr", mem_write, 0);
    check("rst_mid_rd", mem_read, 0);
    check("rst_mid_acc", cnt_access, 0);
    check("rst_mid_wb", cnt_wb, 0);
    @(negedge clk);
    reset    = 1'b0;
    l2_read  = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk);

    req(1, 0, 28'h30, '0, q, cyc);
    check("post_rst_cyc", cyc, 3);
    check("post_rst_rdata", q, {4{32'h0000_0030}});
    check("post_rst_acc", cnt_access, 1);
    check("post_rst_hit", cnt_hit, 0);

    l2_read  = 1'b1;
    l2_write = 1'b1;
    l2_addr  = 28'h30;
    #1;
    check("idle_ready", l2_ready, 1);
    check("idle_rdata", l2_rdata, 0);
    repeat (3) @(negedge clk);
    check("idle_mem_rd", mem_read, 0);
    check("idle_mem_wr", mem_write, 0);
    check("idle_acc", cnt_access, 1);
    check("idle_hit", cnt_hit, 0);
    l2_write = 1'b0;
    req(1, 0, 28'h30, '0, q, cyc);
    check("after_idle_cyc", cyc, 1);
    check("after_idle_hit", cnt_hit, 1);
    check("no_overlap", n_overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/l2_cache_assoc.md
Name: l2_cache_assoc

Overview:
- Parametrised, N-way set-associative, write-back/write-allocate L2 cache between the L1 caches and main memory.
- Lines are DATA_W bits wide. Addresses are line addresses, with no byte offset.
- Replacement is true LRU using per-way age counters.
- Built-in performance counters replace the ad-hoc debug counters of the direct-mapped L2.

Parameters:
- ADDR_W, 28, line-address width.
- DATA_W, 128, line width.
- SET_BITS, 4, log2 of the set count. Index is addr[SET_BITS-1:0]; tag is addr[ADDR_W-1:SET_BITS].
- WAYS, 2, associativity. Legal values are 1, 2, 4 and 8.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- l2_read  in  1  L1 read request, held until l2_ready.
- l2_write  in  1  L1 write request (full line), held until l2_ready.
- l2_addr  in  ADDR_W  request line address.
- l2_wdata  in  DATA_W  write line.
- l2_rdata  out  DATA_W  read line; valid when l2_ready and l2_read.
- l2_ready  out  1  request completes this cycle (combinational).
- mem_read  out  1  memory read request (registered).
- mem_write  out  1  memory write request (registered).
- mem_addr  out  ADDR_W  memory line address (registered).
- mem_wdata  out  DATA_W  writeback line (registered).
- mem_rdata  in  DATA_W  fill data, valid with mem_ready.
- mem_ready  in  1  memory completes the current request this cycle.
- cnt_access  out  CNT_W  completed requests.
- cnt_hit  out  CNT_W  requests that hit on their first lookup cycle.
- cnt_wb  out  CNT_W  dirty writebacks issued.

Behaviour:
- Reset (async) clears:
  - all valid, dirty, tag, data and age state;
  - mem_read, mem_write, mem_addr, mem_wdata and all counters to 0;
  - state to LOOKUP.
- Reset mid-miss aborts the transaction; mem_read and mem_write drop immediately.
- Request = l2_read XOR l2_write. Both high or both low means idle:
  - l2_ready=1, l2_rdata=0;
  - no state, age or counter change.
- Hit: some way w in the indexed set has valid=1 and a matching tag. Ways are mutually exclusive by construction.

LOOKUP state:
- Hit:
  - l2_ready=1 in the same cycle.
  - Read: l2_rdata = data[set][w].
  - Write: data[set][w] <= l2_wdata and dirty <= 1 at the clock edge.
  - Ages update as described under LRU.
  - cnt_access increments.
  - cnt_hit increments only if this was the first lookup cycle of the request (no miss since the previous completion).
- Miss:
  - l2_ready=0.
  - Victim is the lowest-index invalid way; otherwise the way with age = WAYS-1.
  - Victim index and way are latched.
  - Victim valid and dirty: mem_write<=1, mem_addr<={victim tag, index}, mem_wdata<=victim data, cnt_wb increments; go to WRITEBACK.
  - Otherwise: mem_read<=1, mem_addr<=l2_addr; go to FILL.

WRITEBACK state:
- l2_ready=0.
- On mem_ready: mem_write<=0, mem_read<=1, mem_addr<=l2_addr; go to FILL.

FILL state:
- l2_ready=0.
- On mem_ready, the victim way receives: data=mem_rdata, tag from l2_addr, valid=1, dirty=0. Then mem_read<=0 and go to LOOKUP.
- The request then hits next cycle: write-allocate completes there, and the access is not counted in cnt_hit.

General rules:
- mem_read/mem_write are never both 1.
- mem_read/mem_write stay asserted, with stable addr/wdata, until mem_ready.

LRU:
- Each way has an age of log2(WAYS) bits.
- On a hit to way w, age[w]<=0 and every way with age < old age[w] increments.
- A fill counts as an access to the victim when the following hit occurs.
- Ages within a set stay a permutation of 0..WAYS-1; reset initialises age[w]=w.
- WAYS=1 degenerates to direct-mapped with no age storage.

Latency:
- Hit: 0 extra cycles.
- Clean miss: 1 lookup cycle, then memory latency, then 1 lookup cycle.
- Dirty miss: adds one more memory transaction.

Counters wrap modulo 2^CNT_W.

Decomposition:
- Package l2_cache_pkg: state enum (LOOKUP, WRITEBACK, FILL) and a helper for log2(WAYS).
- Sub-module l2_lru_set:
  - per-set age vector and update logic;
  - inputs: access_valid, access_way;
  - outputs: victim_way (max age) and the ages.
  - Instantiated once per set, or as one shared update unit over an age array.

Test Plan (SET_BITS=4, WAYS=2):
- After reset, read 0x0000010 -> one cycle with mem_read=1, mem_addr=0x0000010; mem_ready with mem_rdata=0xA5..A5 -> next cycle l2_ready=1, l2_rdata=0xA5..A5; cnt_access=1, cnt_hit=0.
- Fill 0x10 and 0x20 (both set 0), then read both -> both hit with no mem activity, showing two ways coexist; cnt_hit=2.
- Sequence: write 0x10 data D1; read 0x20; read 0x30 -> victim is way holding 0x10 (LRU, dirty). Required: mem_write=1, mem_addr=0x10, mem_wdata=D1, then mem_read with mem_addr=0x30; cnt_wb=1.
- Write miss to clean set 5 (addr 0x45) -> fill, then the write lands. A later eviction writes back l2_wdata, not the fill data.
- Assert reset while in WRITEBACK with mem_write=1 -> mem_write=0 immediately; all lines invalid; a read of the old address misses again.
- Drive l2_read=l2_write=1 -> l2_ready=1, no mem request, counters unchanged.
